// File: rtl/leaf_stream_fifo.sv
// leaf_stream_fifo: first-word-fall-through elastic buffer for one ap_vld/ap_ack stream.
// Define LEAF_FIFO_STATS_EN to expose the count and max_count (high watermark) ports.
module leaf_stream_fifo #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH_BITS   = 4,
  parameter int unsigned AFULL_THRESH = 12
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_ap_vld,
  output logic                  din_ap_ack,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_ap_vld,
  input  logic                  dout_ap_ack,
  output logic                  almost_full
`ifdef LEAF_FIFO_STATS_EN
  ,
  output logic [DEPTH_BITS:0]   count,
  output logic [DEPTH_BITS:0]   max_count
`endif
);

  localparam int unsigned DEPTH = 2 ** DEPTH_BITS;
  localparam int unsigned CW    = DEPTH_BITS + 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_CNT = CW'(AFULL_THRESH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH_BITS-1:0] r_wr_ptr;
  logic [DEPTH_BITS-1:0] r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic [CW-1:0]         w_count_nxt;
  logic                  r_full;
  logic                  r_empty;
  logic                  r_afull;
  logic                  w_wr;
  logic                  w_rd;

  // Acceptance depends only on registered state and reset, never on din_ap_vld.
  assign din_ap_ack  = ~r_full & ~ap_rst;
  assign dout_ap_vld = ~r_empty;
  assign dout        = r_mem[r_rd_ptr];
  assign almost_full = r_afull;
  assign w_wr        = din_ap_vld & din_ap_ack;
  assign w_rd        = dout_ap_vld & dout_ap_ack;

  always_comb begin
    w_count_nxt = r_count;
    if (w_wr && !w_rd) begin
      w_count_nxt = r_count + CW'(1);
    end else if (w_rd && !w_wr) begin
      w_count_nxt = r_count - CW'(1);
    end
  end

  // Storage is not cleared on reset; a flush only rewinds the pointers.
  always_ff @(posedge ap_clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_afull  <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + DEPTH_BITS'(1);
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + DEPTH_BITS'(1);
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == FULL_CNT);
      r_empty <= (w_count_nxt == '0);
      r_afull <= (w_count_nxt >= AFULL_CNT);
    end
  end

`ifdef LEAF_FIFO_STATS_EN
  logic [CW-1:0] r_max_count;

  // High watermark tracks the post-update occupancy; only reset clears it.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_max_count <= '0;
    end else if (w_count_nxt > r_max_count) begin
      r_max_count <= w_count_nxt;
    end
  end

  assign count     = r_count;
  assign max_count = r_max_count;
`endif

endmodule

// File: tb/tb_leaf_stream_fifo.sv
// tb_leaf_stream_fifo: scoreboard bench for leaf_stream_fifo (either LEAF_FIFO_STATS_EN build).
module tb_leaf_stream_fifo;

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic [31:0] din;
  logic        din_ap_vld;
  logic        din_ap_ack;
  logic [31:0] dout;
  logic        dout_ap_vld;
  logic        dout_ap_ack;
  logic        almost_full;
`ifdef LEAF_FIFO_STATS_EN
  logic [4:0]  count;
  logic [4:0]  max_count;
`endif

  leaf_stream_fifo dut (
    .ap_clk      (ap_clk),
    .ap_rst      (ap_rst),
    .din         (din),
    .din_ap_vld  (din_ap_vld),
    .din_ap_ack  (din_ap_ack),
    .dout        (dout),
    .dout_ap_vld (dout_ap_vld),
    .dout_ap_ack (dout_ap_ack),
    .almost_full (almost_full)
`ifdef LEAF_FIFO_STATS_EN
    ,
    .count       (count),
    .max_count   (max_count)
`endif
  );

  always #5 ap_clk = ~ap_clk;

  logic [31:0] q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          peak     = 0;
  int          n_rx     = 0;
  bit          last_wr  = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] lfsr_next(input logic [31:0] v);
    return {v[30:0], 1'b0} ^ (v[31] ? 32'h04C1_1DB7 : 32'h0);
  endfunction

  // One clock cycle: drive, check pre-edge outputs against the model, then advance the model.
  task automatic step(input logic rst, input logic vld, input logic [31:0] d, input logic ack);
    logic wr;
    logic rd;
    logic [31:0] exp;
    ap_rst      = rst;
    din_ap_vld  = vld;
    din         = d;
    dout_ap_ack = ack;
    #1;
    wr = din_ap_vld & din_ap_ack;
    rd = dout_ap_vld & dout_ap_ack & ~rst;
    if (rst) begin
      check_eq("ack_in_reset", 32'(din_ap_ack), 32'd0);
    end else begin
      check_eq("din_ap_ack", 32'(din_ap_ack), 32'(q.size() != 16));
      check_eq("dout_ap_vld", 32'(dout_ap_vld), 32'(q.size() != 0));
      check_eq("almost_full", 32'(almost_full), 32'(q.size() >= 12));
`ifdef LEAF_FIFO_STATS_EN
      check_eq("count", 32'(count), 32'(q.size()));
      check_eq("max_count", 32'(max_count), 32'(peak));
`endif
      if (q.size() != 0 && !rd) check_eq("dout_hold", dout, q[0]);
      if (rd) begin
        if (q.size() == 0) begin
          check_eq("read_when_empty", 32'(dout_ap_vld), 32'd0);
        end else begin
          exp = q.pop_front();
          check_eq("sb_data", dout, exp);
          n_rx++;
        end
      end
      if (wr) q.push_back(d);
      if (q.size() > peak) peak = q.size();
    end
    if (rst) begin
      q.delete();
      peak = 0;
    end
    last_wr = wr;
    @(posedge ap_clk);
    #1;
  endtask

  initial begin
    logic [31:0] lfsr;
    logic [31:0] p_data;
    bit          p_vld;
    int          tx;
    int          ack_pct;

    // Reset, then a single word held until acked.
    step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b0);

    // Fill to full with the consumer stalled, then try a 17th word.
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 32'(i), 1'b0);
    step(1'b0, 1'b1, 32'h0000_0999, 1'b0);
    step(1'b0, 1'b1, 32'h0000_0999, 1'b0);

    // One read from full frees a slot for the held word on the following cycle.
    step(1'b0, 1'b1, 32'h0000_0999, 1'b1);
    step(1'b0, 1'b1, 32'h0000_0999, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 17; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

    // Continuous streaming across two pointer wraps.
    for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 32'h100 + 32'(i), 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b0);

    // Random stalls with LFSR payloads; consumer speed alternates to reach full and empty.
    step(1'b1, 1'b0, 32'h0, 1'b0);
    lfsr  = 32'h0000_0001;
    p_vld = 1'b0;
    p_data = 32'h0;
    tx    = 0;
    n_rx  = 0;
    for (int cyc = 0; cyc < 60000 && n_rx < 10000; cyc++) begin
      ack_pct = ((cyc / 500) % 2 == 0) ? 30 : 90;
      if (!p_vld && tx < 10000 && $urandom_range(0, 99) < 75) begin
        p_vld  = 1'b1;
        p_data = lfsr;
        lfsr   = lfsr_next(lfsr);
      end
      step(1'b0, p_vld, p_data, $urandom_range(0, 99) < ack_pct);
      if (last_wr) begin
        p_vld = 1'b0;
        tx++;
      end
    end
    check_eq("rand_words_rx", 32'(n_rx), 32'd10000);
    check_eq("rand_words_left", 32'(q.size()), 32'd0);

    // Reset with seven words queued and a write in flight.
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 32'h200 + 32'(i), 1'b0);
    step(1'b1, 1'b1, 32'hBAD0_BAD0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 32'h0000_0001, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
